// File: rtl/timer_periph_pkg.sv
// ---------------------------------------------------------------------------
// timer_periph_pkg
//   Shared definitions for the memory-mapped timer peripheral:
//   - default base address of the register block
//   - register offsets within the 16-byte block
//   - TCON bit positions
//   - a small helper that rebuilds a register offset from the word index
// ---------------------------------------------------------------------------
package timer_periph_pkg;

  // Byte address of TH; the block occupies BASE .. BASE+0x0F.
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h4000_0000;

  // Register offsets (byte offsets from the base address).
  localparam logic [3:0] TH_OFF      = 4'h0;
  localparam logic [3:0] TL_OFF      = 4'h4;
  localparam logic [3:0] TCON_OFF    = 4'h8;
  localparam logic [3:0] SYSTICK_OFF = 4'hC;

  // TCON bit indices. Bits 31:3 read as zero and ignore writes.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  // Bus addresses are word aligned; the byte lane bits are dropped and the
  // word index is turned back into a byte offset for comparison against the
  // *_OFF constants above.
  function automatic logic [3:0] reg_offset(input logic [1:0] word_idx);
    return {word_idx, 2'b00};
  endfunction

endpackage

// File: rtl/timer_periph_if.sv
// ---------------------------------------------------------------------------
// timer_periph_if
//   Data-memory bus slice seen by the timer peripheral.
//
//   Signals:
//     rd_en  - read strobe (MemRead)
//     wr_en  - write strobe (MemWrite)
//     addr   - byte address, addr[1:0] ignored by the slave
//     wdata  - write data
//     rdata  - read data, combinational from the slave
//
//   Handshake: rd_en/wr_en act as per-cycle valid strobes and the slave is
//   always ready, so every strobed cycle completes in that same cycle. A
//   read returns data combinationally in the strobed cycle; a write is
//   committed on the rising clock edge that ends the strobed cycle. Both
//   strobes may be high together: the write commits and rdata shows the
//   value held before that edge.
//
//   Modports:
//     master - the CPU side (drives strobes, address and write data)
//     slave  - the peripheral side (drives rdata)
// ---------------------------------------------------------------------------
interface timer_periph_if;

  logic        rd_en;
  logic        wr_en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output rd_en,
    output wr_en,
    output addr,
    output wdata,
    input  rdata
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  addr,
    input  wdata,
    output rdata
  );

endinterface

// File: rtl/timer_periph_prescaler.sv
// ---------------------------------------------------------------------------
// timer_periph_prescaler
//   Divides enabled clock cycles by PRESCALE and produces a one-cycle tick.
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset
//     en     - count enable (TCON.EN)
//     tick   - high in the enabled cycle where the count reaches PRESCALE-1
//
//   While en is low the count is held at zero, so disabling the timer throws
//   away any partial progress towards the next tick. PRESCALE must lie in
//   1..65535; with PRESCALE=1 the count never leaves zero and tick follows en.
// ---------------------------------------------------------------------------
module timer_periph_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(PRESCALE - 1);

  logic [15:0] pcnt;

  assign tick = en && (pcnt == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt <= '0;
    end else if (!en) begin
      pcnt <= '0;
    end else if (pcnt == LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + 16'd1;
    end
  end

endmodule

// File: rtl/timer_periph.sv
// ---------------------------------------------------------------------------
// timer_periph
//   Memory-mapped reloading timer plus free-running system tick counter for
//   the single-cycle MIPS data-memory bus.
//
//   Registers (offsets from BASE_ADDR):
//     0x00 TH      reload value, R/W
//     0x04 TL      counter, R/W
//     0x08 TCON    bit0 EN, bit1 IE, bit2 IS (interrupt status), R/W
//     0x0C SYSTICK free-running cycle count, read-only
//
//   Ports:
//     clk    - system clock
//     reset  - synchronous, active-high reset
//     bus    - data-memory bus slice (slave modport), rdata combinational
//     irq    - interrupt request to the control unit, IE & IS
//
//   TL advances on every prescaler tick. When it is all ones the tick reloads
//   it from TH instead (overflow) and, if IE is set, latches IS. IS stays set
//   until software clears it through TCON; a hardware set in the same cycle
//   as a software clear wins so no overflow is lost.
// ---------------------------------------------------------------------------
module timer_periph
  import timer_periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter int          PRESCALE  = 1
) (
  input  logic            clk,
  input  logic            reset,
  timer_periph_if.slave   bus,
  output logic            irq
);

  // -------------------------------------------------------------------------
  // Register state
  // -------------------------------------------------------------------------
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] systick;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic       hit;
  logic [3:0] off;
  logic       wr_hit;
  logic       we_th;
  logic       we_tl;
  logic       we_tcon;
  logic       unused_addr_bits;

  assign hit    = (bus.addr[31:4] == BASE_ADDR[31:4]);
  assign off    = reg_offset(bus.addr[3:2]);
  assign wr_hit = bus.wr_en && hit;

  assign we_th   = wr_hit && (off == TH_OFF);
  assign we_tl   = wr_hit && (off == TL_OFF);
  assign we_tcon = wr_hit && (off == TCON_OFF);
  // SYSTICK writes decode to nothing and are dropped.

  // Byte lane bits carry no meaning on this word-only block.
  assign unused_addr_bits = ^bus.addr[1:0];

  // -------------------------------------------------------------------------
  // Prescaler and overflow detection
  // -------------------------------------------------------------------------
  logic tick;
  logic overflow;
  logic hw_set;

  timer_periph_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (tcon[TCON_EN]),
    .tick  (tick)
  );

  assign overflow = tick && (tl == 32'hFFFF_FFFF);
  // Uses the IE value held before any same-cycle TCON write.
  assign hw_set   = overflow && tcon[TCON_IE];

  // -------------------------------------------------------------------------
  // Read path: combinational so a single-cycle load sees data immediately.
  // Reads during reset return zero.
  // -------------------------------------------------------------------------
  logic [31:0] rdata_c;

  always_comb begin
    rdata_c = '0;
    if (bus.rd_en && hit && !reset) begin
      unique case (off)
        TH_OFF:      rdata_c = th;
        TL_OFF:      rdata_c = tl;
        TCON_OFF:    rdata_c = {29'd0, tcon};
        SYSTICK_OFF: rdata_c = systick;
        default:     rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;

  // -------------------------------------------------------------------------
  // Register updates
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      th      <= '0;
      tl      <= '0;
      tcon    <= '0;
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;

      // A same-cycle overflow reloads TL from the TH value held before this
      // edge, since non-blocking assignment keeps the old th visible here.
      if (we_th) begin
        th <= bus.wdata;
      end

      // A software TL write takes priority over the tick.
      if (we_tl) begin
        tl <= bus.wdata;
      end else if (tick) begin
        tl <= overflow ? th : (tl + 32'd1);
      end

      if (we_tcon) begin
        tcon[TCON_EN] <= bus.wdata[TCON_EN];
        tcon[TCON_IE] <= bus.wdata[TCON_IE];
        tcon[TCON_IS] <= bus.wdata[TCON_IS] | hw_set;
      end else if (hw_set) begin
        tcon[TCON_IS] <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Interrupt request from registered bits only.
  // -------------------------------------------------------------------------
  assign irq = tcon[TCON_IE] & tcon[TCON_IS];

endmodule
